// File: rtl/tpu_pkg.sv
// Shared types and default sizing for the systolic array control slice.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } ctrl_state_t;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned DEF_ROWS   = 2;
  localparam int unsigned DEF_COLS   = 2;
  localparam int unsigned DEF_ADDR_W = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/systolic_ctrl_skew_line.sv
// skew_line: lane i presents the W-bit source delayed by i clock cycles.
// Lane 0 is a straight pass-through, so registered sources give registered lanes.
module skew_line #(
  parameter int unsigned LANES = 2,
  parameter int unsigned W     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         src,
  output logic [LANES*W-1:0]   dly
);

  generate
    if (LANES == 1) begin : g_pass
      assign dly = src;
    end else begin : g_shift
      logic [(LANES-1)*W-1:0] sh;

      // Each lane feeds the next one a cycle later; the top lane is never stored.
      always_ff @(posedge clk) begin
        if (rst) sh <= '0;
        else     sh <= dly[(LANES-1)*W-1:0];
      end

      assign dly = {sh, src};
    end
  endgenerate

endmodule

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: job sequencer for a ROWS x COLS weight-stationary PE array.
// Loads a weight tile, promotes it with a per-row switch, streams N input
// vectors with per-row skew, flags south-edge psum validity, then pulses done.
// Optional macro SYSTOLIC_CTRL_PERF_EN adds the perf_busy_cycles counter port.
module systolic_ctrl
  import tpu_pkg::*;
#(
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned COLS     = DEF_COLS,
  parameter int unsigned MAX_VECS = 255,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  localparam int unsigned VW      = $clog2(MAX_VECS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [VW-1:0]     n_vecs,
  output logic              busy,
  output logic              done,
  output logic              w_rd_en,
  output logic [ADDR_W-1:0] w_rd_addr,
  output logic              in_rd_en,
  output logic [ADDR_W-1:0] in_rd_addr,
  output logic [COLS-1:0]   accept_w,
  output logic [ROWS-1:0]   sw,
  output logic [ROWS-1:0]   valid,
  output logic [COLS-1:0]   out_valid
`ifdef SYSTOLIC_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_busy_cycles
`endif
);

  localparam int unsigned S         = ROWS + COLS;
  localparam int unsigned PHASE_MAX = max_u(S, MAX_VECS);
  localparam int unsigned PW        = $clog2(PHASE_MAX + 1);

  localparam logic [PW-1:0] S_LAST   = PW'(S - 1);
  localparam logic [PW-1:0] PH_SAT   = PW'(PHASE_MAX - 1);
  localparam logic [PW-1:0] ROWS_PW  = PW'(ROWS);
  localparam logic [PW-1:0] ROWS_M1  = PW'(ROWS - 1);

  ctrl_state_t state, state_n;
  logic [PW-1:0] phase, phase_n, phase_inc, n_last;
  logic [VW-1:0] n_lat, n_lat_n;

  logic              w_rd_en_n, in_rd_en_n;
  logic [ADDR_W-1:0] w_rd_addr_n, in_rd_addr_n;
  logic              acc_src_n, sw_src_n;

  logic acc_src, sw_src, vld_src, ov_src;
  logic [2*ROWS-1:0] row_dly;

  assign phase_inc = (phase == PH_SAT) ? phase : phase + PW'(1);
  assign n_last    = PW'(n_lat) - PW'(1);

  // Next-state, phase counter and next values of the registered outputs.
  always_comb begin
    state_n      = state;
    phase_n      = phase_inc;
    n_lat_n      = n_lat;
    w_rd_en_n    = 1'b0;
    w_rd_addr_n  = '0;
    in_rd_en_n   = 1'b0;
    in_rd_addr_n = '0;
    acc_src_n    = 1'b0;
    sw_src_n     = 1'b0;

    unique case (state)
      IDLE: begin
        phase_n = '0;
        if (start && (n_vecs != '0)) begin
          state_n = LOAD_W;
          n_lat_n = n_vecs;
        end
      end
      LOAD_W: begin
        if (phase == S_LAST) begin
          state_n = STREAM;
          phase_n = '0;
        end
      end
      STREAM: begin
        if (phase == n_last) begin
          state_n = DRAIN;
          phase_n = '0;
        end
      end
      DRAIN: begin
        if (phase == S_LAST) begin
          state_n = DONE;
          phase_n = '0;
        end
      end
      DONE: begin
        state_n = IDLE;
        phase_n = '0;
      end
      default: begin
        state_n = IDLE;
        phase_n = '0;
      end
    endcase

    // Outputs are decoded from the state/phase of the cycle they will appear in.
    if (state_n == LOAD_W) begin
      if (phase_n < ROWS_PW) begin
        w_rd_en_n   = 1'b1;
        w_rd_addr_n = ADDR_W'(ROWS_M1 - phase_n);
      end
      acc_src_n = (phase_n >= PW'(1)) && (phase_n <= ROWS_PW);
    end
    if (state_n == STREAM) begin
      in_rd_en_n   = 1'b1;
      in_rd_addr_n = ADDR_W'(phase_n);
      sw_src_n     = (phase_n == '0);
    end
  end

  // State, counters, registered outputs and skew-line sources.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      n_lat      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      w_rd_en    <= 1'b0;
      w_rd_addr  <= '0;
      in_rd_en   <= 1'b0;
      in_rd_addr <= '0;
      acc_src    <= 1'b0;
      sw_src     <= 1'b0;
      vld_src    <= 1'b0;
      ov_src     <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      n_lat      <= n_lat_n;
      busy       <= (state_n != IDLE);
      done       <= (state_n == DONE);
      w_rd_en    <= w_rd_en_n;
      w_rd_addr  <= w_rd_addr_n;
      in_rd_en   <= in_rd_en_n;
      in_rd_addr <= in_rd_addr_n;
      acc_src    <= acc_src_n;
      sw_src     <= sw_src_n;
      // Row-0 valid trails the input read by one cycle (buffer read latency).
      vld_src    <= (state == STREAM);
      // Column-0 psum is valid one cycle after the bottom row's input enters.
      ov_src     <= valid[ROWS-1];
    end
  end

  skew_line #(.LANES(COLS), .W(1)) u_acc_skew (
    .clk (clk),
    .rst (rst),
    .src (acc_src),
    .dly (accept_w)
  );

  skew_line #(.LANES(ROWS), .W(2)) u_row_skew (
    .clk (clk),
    .rst (rst),
    .src ({vld_src, sw_src}),
    .dly (row_dly)
  );

  skew_line #(.LANES(COLS), .W(1)) u_ov_skew (
    .clk (clk),
    .rst (rst),
    .src (ov_src),
    .dly (out_valid)
  );

  // Split the combined row skew line into per-row switch and valid.
  always_comb begin
    sw    = '0;
    valid = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      sw[r]    = row_dly[2*r];
      valid[r] = row_dly[2*r+1];
    end
  end

`ifdef SYSTOLIC_CTRL_PERF_EN
  // Busy-cycle counter: saturating, cleared only by reset, spans jobs.
  always_ff @(posedge clk) begin
    if (rst)
      perf_busy_cycles <= '0;
    else if (busy && (perf_busy_cycles != '1))
      perf_busy_cycles <= perf_busy_cycles + 32'd1;
  end
`endif

endmodule
